// File: rtl/alu_pkg.sv
// Shared types for the ALU command initiator: operation codes and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd1,
    SUB = 4'd2,
    MUL = 4'd3
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

endpackage

// File: rtl/alu_master_if.sv
// Request, response and ALU command signals of alu_master, bundled in one interface.
interface alu_master_if #(
  parameter int unsigned WIDTH = 8
);

  logic             req_valid_i;
  logic             req_ready_o;
  logic [3:0]       req_cmd_i;
  logic [WIDTH-1:0] req_a_i;
  logic [WIDTH-1:0] req_b_i;

  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH:0]   rsp_data_o;
  logic             rsp_err_o;

  logic             alu_valid_o;
  logic             alu_ready_i;
  logic [3:0]       alu_cmd_o;
  logic [WIDTH-1:0] alu_a_o;
  logic [WIDTH-1:0] alu_b_o;
  logic [WIDTH:0]   alu_x_i;

  modport master (
    input  req_valid_i, req_cmd_i, req_a_i, req_b_i,
    input  rsp_ready_i, alu_ready_i, alu_x_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    output alu_valid_o, alu_cmd_o, alu_a_o, alu_b_o
  );

  modport slave (
    output req_valid_i, req_cmd_i, req_a_i, req_b_i,
    output rsp_ready_i, alu_ready_i, alu_x_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
    input  alu_valid_o, alu_cmd_o, alu_a_o, alu_b_o
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/alu_master.sv
// Initiator for the ALU valid/ready port: holds each command until the ALU answers
// or a watchdog expires, then returns the result on a backpressured response stream.
module alu_master
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  alu_master_if.master     bus,
  output logic [CNT_W-1:0] done_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned RESP_W = WIDTH + 1;
  localparam int unsigned TMO_W  = 8;

  state_e            state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [RESP_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              alu_valid_q, alu_valid_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic accept;
  logic alu_done;
  logic timed_out;

  assign accept    = (state_q == IDLE) && bus.req_valid_i;
  assign alu_done  = (state_q == ISSUE) && bus.alu_ready_i;
  // A ready pulse in the final watchdog cycle still counts as success.
  assign timed_out = (state_q == ISSUE) && !bus.alu_ready_i &&
                     (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      alu_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      err_q       <= err_d;
      alu_valid_q <= alu_valid_d;
      rsp_valid_q <= rsp_valid_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (alu_done || timed_out) state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d       = cmd_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    err_d       = err_q;
    alu_valid_d = alu_valid_q;
    rsp_valid_d = rsp_valid_q;
    tmo_d       = tmo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d       = bus.req_cmd_i;
          a_d         = bus.req_a_i;
          b_d         = bus.req_b_i;
          tmo_d       = '0;
          alu_valid_d = 1'b1;
        end
      end
      ISSUE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (alu_done) begin
          data_d      = bus.alu_x_i;
          err_d       = 1'b0;
          alu_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (timed_out) begin
          data_d      = '0;
          err_d       = 1'b1;
          alu_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.alu_valid_o = alu_valid_q;
  assign bus.alu_cmd_o   = cmd_q;
  assign bus.alu_a_o     = a_q;
  assign bus.alu_b_o     = b_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = data_q;
  assign bus.rsp_err_o   = err_q;

  sat_counter #(.W(CNT_W)) u_done_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (alu_done),
    .count (done_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (timed_out),
    .count (err_cnt_o)
  );

endmodule

// File: tb/tb_alu_master.sv
// Bench for alu_master: a behavioural ALU stub answers commands, a queue holds expected responses.
module tb_alu_master;
  import alu_pkg::*;

  localparam int unsigned CNT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] done_cnt;
  logic [3:0] err_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned exp_done = 0;
  int unsigned exp_err  = 0;

  logic [9:0]  exp_q[$];
  logic [9:0]  exp;

  bit          stub_never  = 1'b0;
  bit          stub_inject = 1'b0;
  int unsigned stub_cnt;

  alu_master_if #(.WIDTH(8)) bus ();

  alu_master #(.WIDTH(8), .TIMEOUT(8), .CNT_W(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .done_cnt_o (done_cnt),
    .err_cnt_o  (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU reference: ADD keeps the carry, SUB/MUL return a zero-extended WIDTH-bit result.
  function automatic logic [8:0] alu_ref(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] t;
    if (c == 4'(ADD)) return {1'b0, a} + {1'b0, b};
    if (c == 4'(SUB)) begin t = a - b; return {1'b0, t}; end
    if (c == 4'(MUL)) begin t = 8'(a * b); return {1'b0, t}; end
    return 9'h000;
  endfunction

  // Stub ALU: sees valid, accepts on the second valid edge, pulses ready for one cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      stub_cnt        <= 0;
      bus.alu_ready_i <= 1'b0;
      bus.alu_x_i     <= '0;
    end else begin
      stub_cnt        <= bus.alu_valid_o ? stub_cnt + 1 : 0;
      bus.alu_ready_i <= (bus.alu_valid_o && stub_cnt == 1 && !stub_never) || stub_inject;
      bus.alu_x_i     <= stub_inject ? 9'h1AB : alu_ref(bus.alu_cmd_o, bus.alu_a_o, bus.alu_b_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a request, pushes its expected response, returns after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                       output int unsigned acc);
    bus.req_valid_i = 1'b1;
    bus.req_cmd_i   = c;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    exp_q.push_back(stub_never ? {1'b1, 9'h000} : {1'b0, alu_ref(c, a, b)});
    for (int i = 0; i < 30 && !bus.req_ready_o; i++) step();
    if (!bus.req_ready_o) begin
      $display("FAIL accept_wait: req_ready_o=%0b required 1 within 30 cycles", bus.req_ready_o);
      $fatal(1);
    end
    step();
    bus.req_valid_i = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_rsp(output int unsigned rc);
    for (int i = 0; i < 40 && !bus.rsp_valid_o; i++) step();
    if (!bus.rsp_valid_o) begin
      $display("FAIL rsp_wait: rsp_valid_o=%0b required 1 within 40 cycles", bus.rsp_valid_o);
      $fatal(1);
    end
    rc = cyc;
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic test_reset();
    step();
    n_checks++;
    if ({bus.alu_valid_o, bus.rsp_valid_o, bus.rsp_err_o, bus.req_ready_o} !== 4'b0001)
      $display("FAIL reset_ctrl: got %b required 0001",
               {bus.alu_valid_o, bus.rsp_valid_o, bus.rsp_err_o, bus.req_ready_o});
    else n_pass++;
    n_checks++;
    if ({bus.rsp_data_o, bus.alu_cmd_o, bus.alu_a_o, bus.alu_b_o, done_cnt, err_cnt} !== '0)
      $display("FAIL reset_data: data=%h cmd=%h a=%h b=%h done=%0d err=%0d required all 0",
               bus.rsp_data_o, bus.alu_cmd_o, bus.alu_a_o, bus.alu_b_o, done_cnt, err_cnt);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ops();
    logic [3:0] cs[3] = '{4'(ADD), 4'(SUB), 4'(MUL)};
    logic [7:0] as[3] = '{8'd5, 8'd3, 8'd16};
    logic [7:0] bs[3] = '{8'd3, 8'd5, 8'd17};
    int unsigned acc;
    bus.rsp_ready_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      issue(cs[n], as[n], bs[n], acc);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({bus.alu_valid_o, bus.alu_cmd_o, bus.alu_a_o, bus.alu_b_o} !== {1'b1, cs[n], as[n], bs[n]})
          $display("FAIL issue_hold[%0d.%0d]: valid=%b cmd=%h a=%h b=%h required 1 %h %h %h", n, k,
                   bus.alu_valid_o, bus.alu_cmd_o, bus.alu_a_o, bus.alu_b_o, cs[n], as[n], bs[n]);
        else n_pass++;
        step();
      end
      // Accept edge plus three ISSUE cycles: response valid in the fourth cycle after accept.
      n_checks++;
      if (bus.rsp_valid_o !== 1'b1 || cyc - acc != 3)
        $display("FAIL rsp_latency[%0d]: rsp_valid=%b after %0d edges required 1 after 3",
                 n, bus.rsp_valid_o, cyc - acc);
      else n_pass++;
      exp = exp_q.pop_front();
      n_checks++;
      if ({bus.rsp_err_o, bus.rsp_data_o} !== exp)
        $display("FAIL op_result[%0d]: got err=%b data=%h required err=%b data=%h",
                 n, bus.rsp_err_o, bus.rsp_data_o, exp[9], exp[8:0]);
      else n_pass++;
      exp_done = sat_inc(exp_done);
      n_checks++;
      if (done_cnt !== 4'(exp_done))
        $display("FAIL op_done_cnt[%0d]: got %0d required %0d", n, done_cnt, exp_done);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_timeout();
    int unsigned acc;
    int unsigned hi = 0;
    bus.rsp_ready_i = 1'b0;
    stub_never = 1'b1;
    issue(4'(ADD), 8'd7, 8'd9, acc);
    for (int i = 0; i < 20 && bus.alu_valid_o; i++) begin
      hi++;
      step();
    end
    n_checks++;
    if (hi != 8) $display("FAIL timeout_valid_len: got %0d cycles required 8", hi);
    else n_pass++;
    exp = exp_q.pop_front();
    exp_err = sat_inc(exp_err);
    n_checks++;
    if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o, err_cnt} !== {1'b1, exp, 4'(exp_err)})
      $display("FAIL timeout_rsp: valid=%b err=%b data=%h err_cnt=%0d required 1 %b %h %0d",
               bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o, err_cnt, exp[9], exp[8:0], exp_err);
    else n_pass++;
    stub_never  = 1'b0;
    stub_inject = 1'b1;
    step();
    stub_inject = 1'b0;
    step();
    n_checks++;
    if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o, done_cnt, err_cnt} !==
        {1'b1, exp, 4'(exp_done), 4'(exp_err)})
      $display("FAIL late_ready: valid=%b err=%b data=%h done=%0d err_cnt=%0d required 1 %b %h %0d %0d",
               bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_data_o, done_cnt, err_cnt,
               exp[9], exp[8:0], exp_done, exp_err);
    else n_pass++;
    bus.rsp_ready_i = 1'b1;
    step();
    n_checks++;
    if ({bus.rsp_valid_o, bus.req_ready_o} !== 2'b01)
      $display("FAIL timeout_release: valid=%b req_ready=%b required 0 1", bus.rsp_valid_o, bus.req_ready_o);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int unsigned acc;
    int unsigned rc;
    bus.rsp_ready_i = 1'b0;
    issue(4'(SUB), 8'd200, 8'd55, acc);
    wait_rsp(rc);
    exp = exp_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({bus.rsp_valid_o, bus.req_ready_o, bus.alu_valid_o, bus.rsp_err_o, bus.rsp_data_o} !==
          {3'b100, exp})
        $display("FAIL bp_hold[%0d]: valid=%b req_ready=%b alu_valid=%b err=%b data=%h required 1 0 0 %b %h",
                 i, bus.rsp_valid_o, bus.req_ready_o, bus.alu_valid_o, bus.rsp_err_o,
                 bus.rsp_data_o, exp[9], exp[8:0]);
      else n_pass++;
      step();
    end
    bus.rsp_ready_i = 1'b1;
    step();
    exp_done = sat_inc(exp_done);
    n_checks++;
    if ({bus.rsp_valid_o, bus.req_ready_o, done_cnt} !== {2'b01, 4'(exp_done)})
      $display("FAIL bp_release: valid=%b req_ready=%b done=%0d required 0 1 %0d",
               bus.rsp_valid_o, bus.req_ready_o, done_cnt, exp_done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned acc, rc, pacc, prc;
    logic [3:0] c;
    logic [7:0] a, b;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      c = 4'($urandom_range(1, 3));
      a = 8'($urandom);
      b = 8'($urandom);
      issue(c, a, b, acc);
      wait_rsp(rc);
      exp = exp_q.pop_front();
      n_checks++;
      if ({bus.rsp_err_o, bus.rsp_data_o, bus.alu_valid_o} !== {exp, 1'b0})
        $display("FAIL b2b_result[%0d]: err=%b data=%h alu_valid=%b required %b %h 0",
                 i, bus.rsp_err_o, bus.rsp_data_o, bus.alu_valid_o, exp[9], exp[8:0]);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (acc - pacc != 5 || rc - prc != 5)
          $display("FAIL b2b_spacing[%0d]: accept gap %0d rsp gap %0d required 5 5", i, acc - pacc, rc - prc);
        else n_pass++;
      end
      exp_done = sat_inc(exp_done);
      pacc = acc;
      prc  = rc;
    end
    n_checks++;
    if (done_cnt !== 4'(exp_done)) $display("FAIL b2b_done_cnt: got %0d required %0d", done_cnt, exp_done);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [3:0] cs[3] = '{4'(ADD), 4'hF, 4'(MUL)};
    logic [7:0] as[3] = '{8'd255, 8'd12, 8'd15};
    logic [7:0] bs[3] = '{8'd255, 8'd34, 8'd15};
    int unsigned acc, rc;
    for (int n = 0; n < 3; n++) begin
      issue(cs[n], as[n], bs[n], acc);
      wait_rsp(rc);
      exp = exp_q.pop_front();
      exp_done = sat_inc(exp_done);
      step();
      n_checks++;
      if (done_cnt !== 4'(exp_done))
        $display("FAIL sat_done_cnt[%0d]: got %0d required %0d", n, done_cnt, exp_done);
      else n_pass++;
      n_checks++;
      if ({bus.rsp_err_o, bus.rsp_data_o} !== exp)
        $display("FAIL sat_result[%0d]: err=%b data=%h required %b %h",
                 n, bus.rsp_err_o, bus.rsp_data_o, exp[9], exp[8:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_issue();
    int unsigned acc, rc;
    issue(4'(ADD), 8'd40, 8'd2, acc);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.alu_valid_o, bus.rsp_valid_o, bus.rsp_err_o, bus.req_ready_o} !== 4'b0001)
      $display("FAIL midreset_ctrl: got %b required 0001",
               {bus.alu_valid_o, bus.rsp_valid_o, bus.rsp_err_o, bus.req_ready_o});
    else n_pass++;
    n_checks++;
    if ({bus.rsp_data_o, bus.alu_cmd_o, bus.alu_a_o, bus.alu_b_o, done_cnt, err_cnt} !== '0)
      $display("FAIL midreset_data: data=%h cmd=%h a=%h b=%h done=%0d err=%0d required all 0",
               bus.rsp_data_o, bus.alu_cmd_o, bus.alu_a_o, bus.alu_b_o, done_cnt, err_cnt);
    else n_pass++;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    #3;
    rst_n = 1'b1;
    step();
    issue(4'(ADD), 8'd1, 8'd1, acc);
    wait_rsp(rc);
    exp = exp_q.pop_front();
    n_checks++;
    if ({bus.rsp_err_o, bus.rsp_data_o} !== {1'b0, 9'h002} || exp !== {1'b0, 9'h002})
      $display("FAIL post_reset_add: err=%b data=%h required 0 002", bus.rsp_err_o, bus.rsp_data_o);
    else n_pass++;
    exp_done = sat_inc(exp_done);
    step();
    n_checks++;
    if ({done_cnt, err_cnt} !== {4'(exp_done), 4'(exp_err)})
      $display("FAIL post_reset_cnt: done=%0d err=%0d required %0d %0d", done_cnt, err_cnt, exp_done, exp_err);
    else n_pass++;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_cmd_i   = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.rsp_ready_i = 1'b1;
    test_reset();
    test_ops();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_master.md
Name: alu_master

Overview:
- Initiator for the ALU valid/ready command interface.
- Accepts operations from an upstream request stream and drives the ALU command port. Holds each command through the ALU's two-cycle accept sequence, captures the registered result, and returns it on a response stream with backpressure.
- Adds a timeout watchdog and completion/error counters. Sits between a test/control sequencer and an ALU instance.

Parameters:
- WIDTH, 8, operand width; result is WIDTH+1 bits.
- TIMEOUT, 8, max cycles in ISSUE before abort; legal range 3..255.
- CNT_W, 16, width of the completion and error counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  upstream request valid.
- req_ready_o  out  1  upstream request ready.
- req_cmd_i  in  4  operation code (cmd_e).
- req_a_i  in  WIDTH  operand A.
- req_b_i  in  WIDTH  operand B.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_data_o  out  WIDTH+1  captured result.
- rsp_err_o  out  1  response is a timeout abort.
- alu_valid_o  out  1  to ALU valid.
- alu_ready_i  in  1  from ALU registered ready (one-cycle pulse).
- alu_cmd_o  out  4  to ALU command.
- alu_a_o  out  WIDTH  to ALU operand A.
- alu_b_o  out  WIDTH  to ALU operand B.
- alu_x_i  in  WIDTH+1  from ALU result.
- done_cnt_o  out  CNT_W  saturating count of successful responses.
- err_cnt_o  out  CNT_W  saturating count of timeout responses.

Behaviour:
- Reset: asynchronous, active-low; one clock; all flops reset.
  - State IDLE.
  - alu_valid_o=0, rsp_valid_o=0, rsp_err_o=0.
  - rsp_data_o=0, alu_cmd_o=0, alu_a_o=0, alu_b_o=0.
  - Both counters 0.
- All outputs are registered except req_ready_o, which is decoded as (state==IDLE).
- States (state_e): IDLE, ISSUE, RESP.
- IDLE:
  - On req_valid_i&&req_ready_o, latch cmd/a/b into alu_*_o and clear the timeout counter; go to ISSUE.
  - alu_valid_o=1 from the next cycle.
- ISSUE:
  - alu_valid_o=1; alu_cmd_o/alu_a_o/alu_b_o are held constant.
  - Timeout counter increments every cycle.
  - On alu_ready_i=1: rsp_data_o<=alu_x_i, rsp_err_o<=0, done_cnt++; go to RESP.
  - Else, when count==TIMEOUT-1: rsp_data_o<=0, rsp_err_o<=1, err_cnt++; go to RESP.
  - alu_ready_i and timeout in the same cycle: ready wins, success.
- RESP:
  - alu_valid_o=0, rsp_valid_o=1; data and err are held stable until accepted.
  - alu_ready_i is ignored; a late pulse after abort is discarded.
  - On rsp_ready_i=1: rsp_valid_o<=0; go to IDLE.
- Nominal latency:
  - Request accept at cycle k → alu_valid_o high at k+1..k+3.
  - ALU accepts at k+2; alu_ready_i at k+3.
  - rsp_valid_o at k+4.
- Throughput: with rsp_ready_i held high, one operation per 5 cycles.
- alu_valid_o is low for at least one cycle (RESP) between operations, which guarantees the ALU returns to IDLE before the next command.
- Undefined cmd codes are forwarded unchanged; the ALU returns 0, which is reported as success.
- No arithmetic in this block; data passes through at WIDTH+1 bits.
- Counters saturate at all-ones; no wrap.
- Reset mid-ISSUE: alu_valid_o drops asynchronously; the ALU sees valid low and returns to IDLE on its own. Any in-flight result is lost.
- req_* inputs are ignored outside IDLE. Upstream must hold request data stable while req_valid_i is high and not accepted.

Decomposition:
- alu_pkg holds:
  - cmd_e (ADD=1, SUB=2, MUL=3, 4-bit) and state_e.
  - Localparam RESP_W = WIDTH+1 is computed per instance.
- One sub-module: sat_counter (param W; inputs clk, rst_n, inc; output count), instantiated twice for done/err.

Test Plan:
- WIDTH=8, ADD a=5 b=3 into a real ALU → rsp_data_o=9'h008, rsp_err_o=0, rsp_valid_o 4 cycles after accept, done_cnt_o=1.
- SUB a=3 b=5 → rsp_data_o=9'h0FE; then MUL a=16 b=17 → 9'h010.
  - Check alu_cmd_o/a/b stable for all three ISSUE cycles.
- ALU stub never pulses ready, TIMEOUT=8 → alu_valid_o high exactly 8 cycles, then rsp_err_o=1, rsp_data_o=0, err_cnt_o=1.
  - A stub ready pulse injected in RESP has no effect.
- rsp_ready_i low 6 cycles after rsp_valid_o → data/err held, req_ready_o=0, alu_valid_o=0 throughout.
  - Accept on cycle 7 → IDLE next cycle.
- 10 back-to-back requests with rsp_ready_i=1 → 10 responses in order, 5 cycles apart, done_cnt_o=10.
  - alu_valid_o low ≥1 cycle between operations.
- Assert rst_ni low mid-ISSUE, asynchronous to clk → alu_valid_o=0 before the next edge, all outputs at reset values.
  - After release, a fresh ADD 1+1 → 9'h002.
